// File: rtl/output_fifo.sv
// Per-column psum FIFOs that re-align skewed array outputs into full rows.
// Optional sticky overflow flag is built when OUTPUT_FIFO_OVF_FLAG_EN is defined.
module output_fifo #(
    parameter int col     = 4,
    parameter int psum_bw = 16,
    parameter int depth   = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [psum_bw*col-1:0]   in,
    input  logic [col-1:0]           wr,
    input  logic                     rd,
    output logic [psum_bw*col-1:0]   out,
    output logic                     o_valid,
    output logic                     o_full,
    output logic                     o_ready,
    output logic                     o_ovf
);

    localparam int AW = $clog2(depth);
    localparam int PW = AW + 1;

    logic [psum_bw-1:0] mem_q [col][depth];
    logic [PW-1:0]      wr_ptr_q [col];
    logic [PW-1:0]      wr_ptr_d [col];
    logic [PW-1:0]      rd_ptr_q [col];
    logic [PW-1:0]      rd_ptr_d [col];
    logic [col-1:0]     empty_v;
    logic [col-1:0]     full_v;
    logic [col-1:0]     wr_ok;
    logic               pop;

    // Status is decoded only from registered pointers, so a write and pop in
    // the same cycle both see the pre-edge full/empty state.
    always_comb begin
        empty_v = '0;
        full_v  = '0;
        for (int c = 0; c < col; c++) begin
            empty_v[c] = (wr_ptr_q[c] == rd_ptr_q[c]);
            full_v[c]  = (wr_ptr_q[c][AW-1:0] == rd_ptr_q[c][AW-1:0]) &&
                         (wr_ptr_q[c][AW] != rd_ptr_q[c][AW]);
        end
    end

    assign o_valid = ~|empty_v;
    assign o_full  = |full_v;
    assign o_ready = ~o_full;
    assign pop     = rd & o_valid;
    assign wr_ok   = wr & ~full_v;

    always_comb begin
        for (int c = 0; c < col; c++) begin
            wr_ptr_d[c] = wr_ptr_q[c] + {{AW{1'b0}}, wr_ok[c]};
            rd_ptr_d[c] = rd_ptr_q[c] + {{AW{1'b0}}, pop};
        end
    end

    always_comb begin
        out = '0;
        if (o_valid) begin
            for (int c = 0; c < col; c++) begin
                out[c*psum_bw +: psum_bw] = mem_q[c][rd_ptr_q[c][AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < col; c++) begin
            if (reset) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
            end else begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
            end
        end
    end

    // Storage is intentionally left unreset; out is masked while any column is empty.
    always_ff @(posedge clk) begin
        for (int c = 0; c < col; c++) begin
            if (!reset && wr_ok[c]) begin
                mem_q[c][wr_ptr_q[c][AW-1:0]] <= in[c*psum_bw +: psum_bw];
            end
        end
    end

`ifdef OUTPUT_FIFO_OVF_FLAG_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (|(wr & full_v)) begin
            ovf_q <= 1'b1;
        end
    end

    assign o_ovf = ovf_q;
`else
    assign o_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_output_fifo.sv
// Directed bench for output_fifo: skewed fill, streaming, full/overflow, wrap and reset,
// with a row scoreboard fed at write time and drained on each pop.
module tb_output_fifo;

    localparam int COL   = 4;
    localparam int PB    = 16;
    localparam int DEPTH = 8;
    localparam int W     = COL * PB;

    logic           clk;
    logic           reset;
    logic [W-1:0]   in;
    logic [COL-1:0] wr;
    logic           rd;
    logic [W-1:0]   out;
    logic           o_valid;
    logic           o_full;
    logic           o_ready;
    logic           o_ovf;

    logic [W-1:0] exp_q[$];
    int checks;
    int errors;

    output_fifo #(.col(COL), .psum_bw(PB), .depth(DEPTH)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in),
        .wr      (wr),
        .rd      (rd),
        .out     (out),
        .o_valid (o_valid),
        .o_full  (o_full),
        .o_ready (o_ready),
        .o_ovf   (o_ovf)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout observed no_finish expected finish");
        $fatal(1, "timeout");
    end

    function automatic logic [PB-1:0] mk(input int row, input int c);
        return PB'(16'h10 + c + row * 16'h100);
    endfunction

    function automatic logic [W-1:0] row_word(input int row);
        logic [W-1:0] w;
        w = '0;
        for (int c = 0; c < COL; c++) w[c*PB +: PB] = mk(row, c);
        return w;
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [W-1:0] e;
        chk({tag, "_valid"}, W'(o_valid), W'(1'b1));
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed pop expected empty_scoreboard", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, out, e);
        end
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    task automatic write_skewed(input int nrows, input int base);
        int r;
        for (int t = 0; t < nrows + COL - 1; t++) begin
            wr = '0;
            for (int c = 0; c < COL; c++) begin
                r = t - c;
                if (r >= 0 && r < nrows) begin
                    wr[c] = 1'b1;
                    in[c*PB +: PB] = mk(base + r, c);
                end else begin
                    in[c*PB +: PB] = PB'($urandom);
                end
            end
            if (t < nrows) exp_q.push_back(row_word(base + t));
            tick();
        end
        wr = '0;
    endtask

    initial begin
        logic [W-1:0] rw;
        logic exp_ovf;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        in = '0;
        wr = '0;
        rd = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // reset state
        chk("rst_valid", W'(o_valid), W'(1'b0));
        chk("rst_full", W'(o_full), W'(1'b0));
        chk("rst_ready", W'(o_ready), W'(1'b1));
        chk("rst_out", out, '0);
        chk("rst_ovf", W'(o_ovf), W'(1'b0));

        // skewed fill of one row
        for (int c = 0; c < COL; c++) begin
            in = W'({$urandom, $urandom});
            in[c*PB +: PB] = PB'(16'h10 + c);
            wr = COL'(1) << c;
            if (c == 0) exp_q.push_back(64'h0013_0012_0011_0010);
            tick();
            chk("skew_valid", W'(o_valid), W'(c == COL - 1));
        end
        wr = '0;
        chk("skew_out", out, 64'h0013_0012_0011_0010);
        pop_check("skew_pop");
        chk("skew_empty_valid", W'(o_valid), W'(1'b0));
        chk("skew_empty_out", out, '0);

        // streaming: 8 skewed rows, then rd held for 8 cycles
        write_skewed(8, 1);
        rd = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("stream_valid", W'(o_valid), W'(1'b1));
            rw = exp_q.pop_front();
            chk("stream_data", out, rw);
            tick();
        end
        chk("stream_end_valid", W'(o_valid), W'(1'b0));
        chk("stream_end_out", out, '0);
        // rd while empty must not move pointers
        tick();
        rd = 1'b0;
        write_skewed(1, 20);
        pop_check("rd_empty_ignored");

        // full and overflow on column 0
        for (int i = 0; i < DEPTH; i++) begin
            wr = 4'b0001;
            in = '0;
            in[PB-1:0] = PB'(16'hA0 + i);
            tick();
            chk("full_flag", W'(o_full), W'(i == DEPTH - 1));
            chk("full_ready", W'(o_ready), W'(i != DEPTH - 1));
            chk("ovf_pre", W'(o_ovf), W'(1'b0));
        end
        in[PB-1:0] = 16'h00EE;
        tick();
        wr = '0;
`ifdef OUTPUT_FIFO_OVF_FLAG_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        chk("ovf_flag", W'(o_ovf), W'(exp_ovf));
        tick();
        chk("ovf_sticky", W'(o_ovf), W'(exp_ovf));
        for (int i = 0; i < DEPTH; i++) begin
            wr = 4'b1110;
            rw = {PB'(16'hD0 + i), PB'(16'hC0 + i), PB'(16'hB0 + i), PB'(16'hA0 + i)};
            in = rw;
            exp_q.push_back(rw);
            tick();
        end
        // every column full: write with a simultaneous pop is still dropped
        wr = 4'b1111;
        in = {4{16'hFFFF}};
        rd = 1'b1;
        rw = exp_q.pop_front();
        chk("fullpop_data", out, rw);
        tick();
        wr = '0;
        rd = 1'b0;
        chk("fullpop_full", W'(o_full), W'(1'b0));
        for (int i = 0; i < DEPTH - 1; i++) pop_check("full_drain");
        chk("full_drained", W'(o_valid), W'(1'b0));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("ovf_cleared", W'(o_ovf), W'(1'b0));

        // wrap: concurrent write and pop for 3*DEPTH cycles
        rw = W'({$urandom, $urandom});
        in = rw;
        wr = 4'b1111;
        exp_q.push_back(rw);
        tick();
        rd = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) begin
            chk("wrap_valid", W'(o_valid), W'(1'b1));
            rw = exp_q.pop_front();
            chk("wrap_data", out, rw);
            rw = W'({$urandom, $urandom});
            in = rw;
            exp_q.push_back(rw);
            tick();
            chk("wrap_full", W'(o_full), W'(1'b0));
        end
        wr = '0;
        rd = 1'b0;
        pop_check("wrap_last");
        chk("wrap_empty", W'(o_valid), W'(1'b0));

        // mid-operation reset with three rows queued
        for (int i = 0; i < 3; i++) begin
            rw = row_word(40 + i);
            in = rw;
            wr = 4'b1111;
            exp_q.push_back(rw);
            tick();
        end
        chk("mid_valid_pre", W'(o_valid), W'(1'b1));
        reset = 1'b1;
        rd = 1'b1;
        in = {4{16'h7777}};
        tick();
        reset = 1'b0;
        rd = 1'b0;
        wr = '0;
        exp_q.delete();
        chk("mid_valid", W'(o_valid), W'(1'b0));
        chk("mid_full", W'(o_full), W'(1'b0));
        chk("mid_out", out, '0);
        rw = 64'h5555_AAAA_1234_8765;
        in = rw;
        wr = 4'b1111;
        exp_q.push_back(rw);
        tick();
        wr = '0;
        pop_check("mid_row");
        chk("mid_done", W'(o_valid), W'(1'b0));

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
